// File: rtl/mul16_seq_ctrl.sv
// 16x16 unsigned multiplier sequencer: time-multiplexes one external 8x8 core
// over the LL/LH/HL/HH partial products and accumulates them into a 32-bit result.
module mul16_seq_ctrl #(
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic        busy
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid, once raised, holds its payload stable until that edge.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_LH = 2'd1;
    localparam logic [1:0] STEP_HL = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

    state_t      state;
    logic [1:0]  step;
    logic [3:0]  mask;      // steps still pending, bit index equals step code
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [31:0] acc;

    logic [3:0]  new_mask;
    logic [3:0]  remaining;
    logic [31:0] pp_shifted;

    function automatic logic [3:0] build_mask(input logic [15:0] a, input logic [15:0] b);
        logic [3:0] m;
        m = 4'b1111;
        if (ZERO_SKIP) begin
            m[STEP_LL] = (a[7:0]  != 8'd0) && (b[7:0]  != 8'd0);
            m[STEP_LH] = (a[7:0]  != 8'd0) && (b[15:8] != 8'd0);
            m[STEP_HL] = (a[15:8] != 8'd0) && (b[7:0]  != 8'd0);
            m[STEP_HH] = (a[15:8] != 8'd0) && (b[15:8] != 8'd0);
        end
        return m;
    endfunction

    function automatic logic [1:0] first_set(input logic [3:0] m);
        logic [1:0] s;
        if (m[0])      s = STEP_LL;
        else if (m[1]) s = STEP_LH;
        else if (m[2]) s = STEP_HL;
        else           s = STEP_HH;
        return s;
    endfunction

    assign new_mask  = build_mask(in_a, in_b);
    assign remaining = mask & ~(4'b0001 << step);
    assign out_p     = acc;

    always_comb begin
        mul_a = 8'd0;
        mul_b = 8'd0;
        if (state == CALC) begin
            case (step)
                STEP_LL: begin mul_a = a_r[7:0];  mul_b = b_r[7:0];  end
                STEP_LH: begin mul_a = a_r[7:0];  mul_b = b_r[15:8]; end
                STEP_HL: begin mul_a = a_r[15:8]; mul_b = b_r[7:0];  end
                default: begin mul_a = a_r[15:8]; mul_b = b_r[15:8]; end
            endcase
        end
    end

    always_comb begin
        pp_shifted = 32'd0;
        case (step)
            STEP_LL:          pp_shifted = {16'd0, mul_p};
            STEP_LH, STEP_HL: pp_shifted = {8'd0, mul_p, 8'd0};
            default:          pp_shifted = {mul_p, 16'd0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= 2'd0;
            mask      <= 4'd0;
            a_r       <= 16'd0;
            b_r       <= 16'd0;
            acc       <= 32'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= in_a;
                        b_r      <= in_b;
                        acc      <= 32'd0;
                        mask     <= new_mask;
                        step     <= first_set(new_mask);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (new_mask == 4'd0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc  <= acc + pp_shifted;
                    mask <= remaining;
                    if (remaining == 4'd0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        step <= first_set(remaining);
                    end
                end
                DONE: begin
                    // acc is kept after the handshake; it is cleared on the next accept
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Bench for mul16_seq_ctrl: instance 0 runs with ZERO_SKIP=0, instance 1 with
// ZERO_SKIP=1, each fed by a behavioural 8x8 multiplier core.
module tb_mul16_seq_ctrl;
    localparam int N_RAND = 5000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] in_a      [2];
    logic [15:0] in_b      [2];
    logic [7:0]  mul_a     [2];
    logic [7:0]  mul_b     [2];
    logic [15:0] mul_p     [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_p     [2];
    logic        busy      [2];

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    always #5 clk = ~clk;

    assign mul_p[0] = 16'(mul_a[0]) * 16'(mul_b[0]);
    assign mul_p[1] = 16'(mul_a[1]) * 16'(mul_b[1]);

    mul16_seq_ctrl #(.ZERO_SKIP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mul_p[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_p(out_p[0]), .busy(busy[0])
    );

    mul16_seq_ctrl #(.ZERO_SKIP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mul_p[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_p(out_p[1]), .busy(busy[1])
    );

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int z, input logic [15:0] a, input logic [15:0] b, output bit ok);
        int w;
        w = 0;
        ok = 1'b0;
        in_a[z] = a;
        in_b[z] = b;
        in_valid[z] = 1'b1;
        while (!ok && w < 100) begin
            @(negedge clk);
            if (in_ready[z]) ok = 1'b1;
            @(posedge clk);
            #1;
            w++;
        end
        in_valid[z] = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen; -1 on timeout.
    task automatic wait_out_valid(input int z, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid[z]) break;
            @(posedge clk);
            #1;
            lat++;
            if (lat > 30) begin
                lat = -1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [50:0] got;
        for (int z = 0; z < 2; z++) begin
            got = {in_ready[z], out_valid[z], busy[z], mul_a[z], mul_b[z], out_p[z]};
            n_cmp++;
            if (got !== {1'b1, 50'd0}) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d] got %h expected %h", z, got, {1'b1, 50'd0});
            end
        end
    endtask

    task automatic test_full_ones;
        bit ok;
        out_ready[0] = 1'b1;
        send(0, 16'hFFFF, 16'hFFFF, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL full_accept got %b expected 1", ok); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({mul_a[0], mul_b[0], out_valid[0], busy[0]} !== {8'hFF, 8'hFF, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL full_calc[%0d] got a=%h b=%h ov=%b busy=%b expected a=ff b=ff ov=0 busy=1",
                         i, mul_a[0], mul_b[0], out_valid[0], busy[0]);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid[0], in_ready[0], out_p[0], mul_a[0]} !== {1'b1, 1'b0, 32'hFFFE0001, 8'h00}) begin
            n_fail++;
            $display("FAIL full_done got ov=%b ir=%b p=%h ma=%h expected ov=1 ir=0 p=fffe0001 ma=00",
                     out_valid[0], in_ready[0], out_p[0], mul_a[0]);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid[0], in_ready[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL full_after got ov=%b ir=%b expected ov=0 ir=1", out_valid[0], in_ready[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        bit ok;
        int lat;
        out_ready[0] = 1'b0;
        send(0, 16'h1234, 16'h5678, ok);
        wait_out_valid(0, lat);
        n_cmp++;
        if (lat != 4) begin n_fail++; $display("FAIL bp_latency got %0d expected 4", lat); end
        @(posedge clk);
        #1;
        in_a[0] = 16'h0002;
        in_b[0] = 16'h0003;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid[0], in_ready[0], out_p[0]} !== {1'b1, 1'b0, 32'h06260060}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got ov=%b ir=%b p=%h expected ov=1 ir=0 p=06260060",
                         i, out_valid[0], in_ready[0], out_p[0]);
            end
            @(posedge clk);
            #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid[0], in_ready[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release got ov=%b ir=%b expected ov=0 ir=1", out_valid[0], in_ready[0]);
        end
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        wait_out_valid(0, lat);
        n_cmp++;
        if (lat != 4 || out_p[0] !== 32'h00000006) begin
            n_fail++;
            $display("FAIL bp_second got lat=%0d p=%h expected lat=4 p=00000006", lat, out_p[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_skip;
        bit ok;
        out_ready[1] = 1'b1;
        send(1, 16'h00FF, 16'h0100, ok);
        @(negedge clk);
        n_cmp++;
        if ({mul_a[1], mul_b[1], out_valid[1]} !== {8'hFF, 8'h01, 1'b0}) begin
            n_fail++;
            $display("FAIL zs_lh_step got a=%h b=%h ov=%b expected a=ff b=01 ov=0",
                     mul_a[1], mul_b[1], out_valid[1]);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid[1], out_p[1], mul_a[1]} !== {1'b1, 32'h0000FF00, 8'h00}) begin
            n_fail++;
            $display("FAIL zs_lh_result got ov=%b p=%h ma=%h expected ov=1 p=0000ff00 ma=00",
                     out_valid[1], out_p[1], mul_a[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_empty_mask;
        bit ok;
        out_ready[1] = 1'b1;
        send(1, 16'h0000, 16'hABCD, ok);
        @(negedge clk);
        n_cmp++;
        if ({out_valid[1], busy[1], out_p[1], mul_a[1], mul_b[1]} !== {1'b1, 1'b1, 32'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL zs_empty got ov=%b busy=%b p=%h a=%h b=%h expected ov=1 busy=1 p=0 a=0 b=0",
                     out_valid[1], busy[1], out_p[1], mul_a[1], mul_b[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen;
        int lat;
        out_ready[0] = 1'b1;
        send(0, 16'hFFFF, 16'h0002, ok);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready[0], out_valid[0], busy[0], mul_a[0], mul_b[0], out_p[0]} !== {1'b1, 50'd0}) begin
            n_fail++;
            $display("FAIL midreset_outputs got ir=%b ov=%b busy=%b a=%h b=%h p=%h expected ir=1 rest 0",
                     in_ready[0], out_valid[0], busy[0], mul_a[0], mul_b[0], out_p[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_fail++; $display("FAIL midreset_no_result got out_valid=1 expected 0"); end
        @(posedge clk);
        #1;
        send(0, 16'h0003, 16'h0005, ok);
        wait_out_valid(0, lat);
        n_cmp++;
        if (lat != 4 || out_p[0] !== 32'h0000000F) begin
            n_fail++;
            $display("FAIL midreset_next got lat=%0d p=%h expected lat=4 p=0000000f", lat, out_p[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_driver(input int z);
        logic [15:0] a;
        logic [15:0] b;
        bit ok;
        @(posedge clk);
        #1;
        for (int n = 0; n < N_RAND; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a[7:0]  = 8'd0;
            if ($urandom_range(0, 3) == 0) a[15:8] = 8'd0;
            if ($urandom_range(0, 3) == 0) b[7:0]  = 8'd0;
            if ($urandom_range(0, 3) == 0) b[15:8] = 8'd0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(z, a, b, ok);
            if (ok) begin
                if (z == 0) exp_q0.push_back({16'd0, a} * {16'd0, b});
                else        exp_q1.push_back({16'd0, a} * {16'd0, b});
            end else begin
                n_cmp++;
                n_fail++;
                $display("FAIL rand_accept_timeout[%0d] op %0d got no accept expected accept", z, n);
            end
        end
    endtask

    task automatic run_monitor(input int z);
        int got;
        int cyc;
        bit empty;
        logic [31:0] exp;
        got = 0;
        cyc = 0;
        while (got < N_RAND && cyc < 60000) begin
            @(posedge clk);
            #1;
            out_ready[z] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            cyc++;
            if (out_valid[z] && out_ready[z]) begin
                got++;
                empty = 1'b0;
                exp = 32'd0;
                if (z == 0) begin
                    if (exp_q0.size() == 0) empty = 1'b1; else exp = exp_q0.pop_front();
                end else begin
                    if (exp_q1.size() == 0) empty = 1'b1; else exp = exp_q1.pop_front();
                end
                n_cmp++;
                if (empty || out_p[z] !== exp) begin
                    n_fail++;
                    $display("FAIL rand_result[%0d] #%0d got %h expected %h (queue empty=%b)",
                             z, got, out_p[z], exp, empty);
                end
            end
        end
        n_cmp++;
        if (got != N_RAND) begin
            n_fail++;
            $display("FAIL rand_count[%0d] got %0d expected %0d", z, got, N_RAND);
        end
    endtask

    task automatic test_random;
        fork
            run_driver(0);
            run_driver(1);
            run_monitor(0);
            run_monitor(1);
        join
        n_cmp++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            n_fail++;
            $display("FAIL rand_leftover got %0d pending expected 0", exp_q0.size() + exp_q1.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int z = 0; z < 2; z++) begin
            in_valid[z]  = 1'b0;
            in_a[z]      = 16'd0;
            in_b[z]      = 16'd0;
            out_ready[z] = 1'b1;
        end
        #12;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_full_ones;
        test_backpressure;
        test_zero_skip;
        test_empty_mask;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
